// File: rtl/frame_blitter.sv
// frame_blitter: copies a clipped rectangle of one of NUM_IMG image ROMs to the plotter.
// Build macro TRANSPARENT_KEY_EN suppresses oPlot for pixels equal to KEY_COLOUR.
module frame_blitter #(
  parameter int H_RES      = 320,
  parameter int V_RES      = 240,
  parameter int X_W        = 9,
  parameter int Y_W        = 8,
  parameter int COLOUR_W   = 3,
  parameter int ADDR_W     = 17,
  parameter int NUM_IMG    = 5,
  parameter int SEL_W      = 3,
  parameter int ROM_LAT    = 1,
  parameter int KEY_COLOUR = 0
) (
  input  logic                        iClock,
  input  logic                        iReset,
  input  logic                        iStart,
  input  logic [SEL_W-1:0]            iSelect,
  input  logic [X_W-1:0]              iX0,
  input  logic [Y_W-1:0]              iY0,
  input  logic [X_W:0]                iWidth,
  input  logic [Y_W:0]                iHeight,
  output logic                        oBusy,
  output logic                        oDone,
  output logic [ADDR_W-1:0]           oRomAddr,
  input  logic [NUM_IMG*COLOUR_W-1:0] iRomData,
  output logic                        oPlot,
  output logic [X_W-1:0]              oX,
  output logic [Y_W-1:0]              oY,
  output logic [COLOUR_W-1:0]         oColour
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [X_W+1:0] LP_HRES = (X_W+2)'(H_RES);
  localparam logic [Y_W+1:0] LP_VRES = (Y_W+2)'(V_RES);
  localparam logic [X_W+1:0] LP_XMAX = (X_W+2)'(H_RES - 1);
  localparam logic [Y_W+1:0] LP_YMAX = (Y_W+2)'(V_RES - 1);

  state_t             r_state;
  logic [SEL_W-1:0]   r_sel;
  logic [X_W-1:0]     r_xs;
  logic [X_W-1:0]     r_xe;
  logic [Y_W-1:0]     r_ye;
  logic [X_W-1:0]     r_xc;
  logic [Y_W-1:0]     r_yc;

  logic [ROM_LAT-1:0] r_pv;
  logic [X_W-1:0]     r_px [ROM_LAT];
  logic [Y_W-1:0]     r_py [ROM_LAT];
  logic               r_ov;

  logic [X_W+1:0]     w_xsum;
  logic [Y_W+1:0]     w_ysum;
  logic               w_empty;
  logic [X_W-1:0]     w_in_xe;
  logic [Y_W-1:0]     w_in_ye;
  logic               w_idle;
  logic [X_W-1:0]     w_cx;
  logic [Y_W-1:0]     w_cy;
  logic [X_W-1:0]     w_exs;
  logic [X_W-1:0]     w_exe;
  logic [Y_W-1:0]     w_eye;
  logic               w_xlast;
  logic               w_last;
  logic [X_W-1:0]     w_nx;
  logic [Y_W-1:0]     w_ny;
  logic               w_issue;
  logic               w_tail_v;
  logic               w_pipe_busy;
  logic [COLOUR_W-1:0] w_colour;
  logic               w_show;

  // Clip the requested region at full width so edges never wrap.
  assign w_xsum  = (X_W+2)'(iX0) + (X_W+2)'(iWidth) - (X_W+2)'(1);
  assign w_ysum  = (Y_W+2)'(iY0) + (Y_W+2)'(iHeight) - (Y_W+2)'(1);
  assign w_empty = (iWidth == '0) | (iHeight == '0)
                 | ((X_W+2)'(iX0) >= LP_HRES)
                 | ((Y_W+2)'(iY0) >= LP_VRES);
  assign w_in_xe = (w_xsum > LP_XMAX) ? LP_XMAX[X_W-1:0]
                                      : w_xsum[X_W-1:0];
  assign w_in_ye = (w_ysum > LP_YMAX) ? LP_YMAX[Y_W-1:0]
                                      : w_ysum[Y_W-1:0];

  // The first pixel is issued straight from the inputs in the start cycle.
  assign w_idle  = (r_state == S_IDLE);
  assign w_cx    = w_idle ? iX0 : r_xc;
  assign w_cy    = w_idle ? iY0 : r_yc;
  assign w_exs   = w_idle ? iX0 : r_xs;
  assign w_exe   = w_idle ? w_in_xe : r_xe;
  assign w_eye   = w_idle ? w_in_ye : r_ye;
  assign w_xlast = (w_cx == w_exe);
  assign w_last  = w_xlast & (w_cy == w_eye);
  assign w_nx    = w_xlast ? w_exs : w_cx + X_W'(1);
  assign w_ny    = w_xlast ? w_cy + Y_W'(1) : w_cy;
  assign w_issue = (r_state == S_RUN)
                 | (w_idle & iStart & ~w_empty);

  assign w_tail_v    = r_pv[ROM_LAT-1];
  assign w_pipe_busy = (|r_pv) | r_ov;

  // Control FSM: scan position, latched job and handshake outputs.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_xs    <= '0;
      r_xe    <= '0;
      r_ye    <= '0;
      r_xc    <= '0;
      r_yc    <= '0;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
    end else begin
      oDone <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (iStart) begin
            r_sel <= iSelect;
            r_xs  <= iX0;
            r_xe  <= w_in_xe;
            r_ye  <= w_in_ye;
            r_xc  <= w_nx;
            r_yc  <= w_ny;
            oBusy <= 1'b1;
            if (w_empty)
              r_state <= S_DONE;
            else if (w_last)
              r_state <= S_DRAIN;
            else
              r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_xc <= w_nx;
          r_yc <= w_ny;
          if (w_last)
            r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!w_pipe_busy)
            r_state <= S_DONE;
        end
        S_DONE: begin
          oDone   <= 1'b1;
          oBusy   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ROM address register, one pixel per clock while scanning.
  always_ff @(posedge iClock) begin
    if (iReset)
      oRomAddr <= '0;
    else if (w_issue)
      oRomAddr <= ADDR_W'(w_cy) * ADDR_W'(H_RES) + ADDR_W'(w_cx);
  end

  // Coordinate/valid delay line matching the ROM read latency.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_pv <= '0;
    end else begin
      r_pv[0] <= w_issue;
      for (int j = 1; j < ROM_LAT; j++)
        r_pv[j] <= r_pv[j-1];
    end
    r_px[0] <= w_cx;
    r_py[0] <= w_cy;
    for (int j = 1; j < ROM_LAT; j++) begin
      r_px[j] <= r_px[j-1];
      r_py[j] <= r_py[j-1];
    end
  end

  // Select the latched image; out-of-range selects read as colour 0.
  always_comb begin
    w_colour = '0;
    for (int k = 0; k < NUM_IMG; k++)
      if (r_sel == SEL_W'(k))
        w_colour = iRomData[k*COLOUR_W +: COLOUR_W];
  end

`ifdef TRANSPARENT_KEY_EN
  assign w_show = (w_colour != COLOUR_W'(KEY_COLOUR));
`else
  assign w_show = 1'b1 | (w_colour == COLOUR_W'(KEY_COLOUR));
`endif

  // Output stage: registered pixel, held while no valid pixel arrives.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_ov    <= 1'b0;
      oPlot   <= 1'b0;
      oX      <= '0;
      oY      <= '0;
      oColour <= '0;
    end else begin
      r_ov  <= w_tail_v;
      oPlot <= w_tail_v & w_show;
      if (w_tail_v) begin
        oX      <= r_px[ROM_LAT-1];
        oY      <= r_py[ROM_LAT-1];
        oColour <= w_colour;
      end
    end
  end

endmodule

// File: tb/tb_frame_blitter.sv
// tb_frame_blitter: table-driven, hand-written and random checks of frame_blitter.
// Two instances (ROM_LAT=1 and ROM_LAT=3) against a raster-order reference model.
module tb_frame_blitter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic        st1, st3;
  logic [2:0]  sel;
  logic [8:0]  x0;
  logic [7:0]  y0;
  logic [9:0]  w;
  logic [8:0]  h;

  logic        p1, b1, d1, p3, b3, d3;
  logic [16:0] a1, a3, a3q1, a3q2;
  logic [8:0]  x1, x3;
  logic [7:0]  y1, y3;
  logic [2:0]  c1, c3;
  logic [14:0] romd1, romd3;

  frame_blitter u_dut1 (
    .iClock(clk), .iReset(rst), .iStart(st1), .iSelect(sel),
    .iX0(x0), .iY0(y0), .iWidth(w), .iHeight(h),
    .oBusy(b1), .oDone(d1), .oRomAddr(a1), .iRomData(romd1),
    .oPlot(p1), .oX(x1), .oY(y1), .oColour(c1)
  );

  frame_blitter #(.ROM_LAT(3)) u_dut3 (
    .iClock(clk), .iReset(rst), .iStart(st3), .iSelect(sel),
    .iX0(x0), .iY0(y0), .iWidth(w), .iHeight(h),
    .oBusy(b3), .oDone(d3), .oRomAddr(a3), .iRomData(romd3),
    .oPlot(p3), .oX(x3), .oY(y3), .oColour(c3)
  );

  function automatic logic [2:0] rom(input int k, input int a);
    if (k == 2) return a[2:0];
    return 3'((a >> (k + 1)) ^ k);
  endfunction

  always @(posedge clk) begin
    a3q1 <= a3;
    a3q2 <= a3q1;
  end

  always_comb begin
    romd1 = '0;
    romd3 = '0;
    for (int k = 0; k < 5; k++) begin
      romd1[k*3 +: 3] = rom(k, int'(a1));
      romd3[k*3 +: 3] = rom(k, int'(a3q2));
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic run(input int d, input int rx0, input int ry0,
                     input int rw, input int rh, input int rsel,
                     input int extra, input string tag,
                     output int np, output int lat);
    int lt, xe, ye, cnt, s, expd, i, bc, pe, nd, ox, oy, oc;
    bit emp, ep, p, bz, dn;
    int qx[$];
    int qy[$];
    int qc[$];
    lt  = (d == 1) ? 1 : 3;
    emp = (rw == 0) || (rh == 0) || (rx0 >= 320) || (ry0 >= 240);
    xe  = (rx0 + rw - 1 > 319) ? 319 : rx0 + rw - 1;
    ye  = (ry0 + rh - 1 > 239) ? 239 : ry0 + rh - 1;
    if (!emp)
      for (int yy = ry0; yy <= ye; yy++)
        for (int xx = rx0; xx <= xe; xx++) begin
          qx.push_back(xx);
          qy.push_back(yy);
          qc.push_back((rsel < 5) ? int'(rom(rsel, yy * 320 + xx)) : 0);
        end
    cnt  = qx.size();
    expd = emp ? 2 : cnt + lt + 3;
    np = 0; lat = -1; bc = 0; pe = 0; nd = 0;
    @(negedge clk);
    x0 = 9'(rx0); y0 = 8'(ry0); w = 10'(rw); h = 9'(rh); sel = 3'(rsel);
    if (d == 1) st1 = 1'b1; else st3 = 1'b1;
    s = cyc;
    for (int c = s + 1; c <= s + expd + 3; c++) begin
      @(negedge clk);
      st1 = 1'b0;
      st3 = 1'b0;
      if (extra > 0 && c - s == extra) begin
        sel = 3'd0; x0 = 9'd0;
        if (d == 1) st1 = 1'b1; else st3 = 1'b1;
      end
      p  = (d == 1) ? p1 : p3;
      bz = (d == 1) ? b1 : b3;
      dn = (d == 1) ? d1 : d3;
      ox = (d == 1) ? int'(x1) : int'(x3);
      oy = (d == 1) ? int'(y1) : int'(y3);
      oc = (d == 1) ? int'(c1) : int'(c3);
      i  = c - s - lt - 1;
      ep = (i >= 0) && (i < cnt);
`ifdef TRANSPARENT_KEY_EN
      if (ep && qc[i] == 0) ep = 1'b0;
`endif
      if (bz) bc++;
      if (dn) begin nd++; lat = c - s; end
      if (p) np++;
      if (p != ep) pe++;
      else if (p && (ox != qx[i] || oy != qy[i] || oc != qc[i])) pe++;
    end
    st1 = 1'b0;
    st3 = 1'b0;
    chk({tag, "_pix"}, pe, 0);
    chk({tag, "_ndone"}, nd, 1);
    chk({tag, "_lat"}, lat, expd);
    chk({tag, "_busy"}, bc, emp ? 1 : expd - 1);
  endtask

  typedef struct {
    int x0, y0, w, h, sel, extra, plots, lat;
  } vec_t;

  vec_t tbl [10];
  int np, lat, n;

  initial begin
    rst = 1'b1; st1 = 1'b0; st3 = 1'b0;
    sel = '0; x0 = '0; y0 = '0; w = '0; h = '0;
    tbl = '{
      '{310, 230,   20,  20, 1, 0, 100, 104},
      '{  0,   0,    0,   5, 0, 0,   0,   2},
      '{320,   0,    4,   4, 0, 0,   0,   2},
      '{  5,   3,    4,   1, 6, 2,   4,   8},
      '{  0, 239,    3,   5, 3, 0,   3,   7},
      '{319,  10,    1,   1, 4, 0,   1,   5},
      '{  0, 240,    5,   5, 1, 0,   0,   2},
      '{100,  50,    7,   3, 4, 0,  21,  25},
      '{  0,   0,    5,   0, 2, 0,   0,   2},
      '{318, 238, 1023, 511, 0, 0,   4,   8}
    };
    repeat (3) @(negedge clk);
    chk("rst_ctl1", {p1, b1, d1}, 0);
    chk("rst_addr1", a1, 0);
    chk("rst_xyc1", {x1, y1, c1}, 0);
    chk("rst_ctl3", {p3, b3, d3}, 0);
    chk("rst_xyc3", {x3, y3, c3}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 10; k++) begin
      run(1, tbl[k].x0, tbl[k].y0, tbl[k].w, tbl[k].h, tbl[k].sel,
          tbl[k].extra, $sformatf("tbl%0d", k), np, lat);
      chk($sformatf("tbl%0d_np", k), np, tbl[k].plots);
      chk($sformatf("tbl%0d_lat_tbl", k), lat, tbl[k].lat);
    end

    run(3, 0, 0, 8, 2, 2, 0, "lat3", np, lat);
    chk("lat3_np", np, 16);
    chk("lat3_lat_tbl", lat, 22);

    @(negedge clk);
    x0 = 0; y0 = 0; w = 40; h = 30; sel = 3; st1 = 1'b1;
    n = 0;
    for (int c = 0; c < 1500 && n < 1000; c++) begin
      @(negedge clk);
      st1 = 1'b0;
      if (p1) n++;
    end
    chk("mid_pre", n, 1000);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_ctl", {p1, b1, d1}, 0);
    chk("mid_addr", a1, 0);
    chk("mid_xyc", {x1, y1, c1}, 0);
    rst = 1'b0;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (p1) n++;
    end
    chk("mid_stale", n, 0);
    run(1, 0, 0, 40, 30, 3, 0, "mid_rerun", np, lat);
    chk("mid_rerun_np", np, 1200);

    for (int k = 0; k < 16; k++) begin
      run((k % 2) ? 3 : 1, $urandom_range(0, 330), $urandom_range(0, 250),
          $urandom_range(0, 12), $urandom_range(0, 6), $urandom_range(0, 7),
          0, $sformatf("rnd%0d", k), np, lat);
    end

    run(1, 0, 0, 320, 240, 2, 0, "full", np, lat);
    chk("full_np", np, 76800);
    chk("full_lat_tbl", lat, 76804);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
